// File: rtl/mem_port_arbiter_if.sv
// Memory port bundle: command, write-data and response channels.
// "master" is the requester side (drives commands and write data),
// "slave" is the memory side (drives responses).
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_BITS = 26,
  parameter int unsigned TAG_W     = 5,
  parameter int unsigned DATA_BITS = 128
);
  logic                 req_cmd_valid;
  logic                 req_cmd_ready;
  logic                 req_cmd_bits_rw;
  logic [ADDR_BITS-1:0] req_cmd_bits_addr;
  logic [TAG_W-1:0]     req_cmd_bits_tag;
  logic                 req_data_valid;
  logic                 req_data_ready;
  logic [DATA_BITS-1:0] req_data_bits_data;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [TAG_W-1:0]     resp_bits_tag;
  logic [DATA_BITS-1:0] resp_bits_data;

  modport master (
    output req_cmd_valid, req_cmd_bits_rw, req_cmd_bits_addr, req_cmd_bits_tag,
    output req_data_valid, req_data_bits_data, resp_ready,
    input  req_cmd_ready, req_data_ready, resp_valid, resp_bits_tag, resp_bits_data
  );

  modport slave (
    input  req_cmd_valid, req_cmd_bits_rw, req_cmd_bits_addr, req_cmd_bits_tag,
    input  req_data_valid, req_data_bits_data, resp_ready,
    output req_cmd_ready, req_data_ready, resp_valid, resp_bits_tag, resp_bits_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-client arbiter sharing one memory port. Commands are granted in IDLE,
// a write command locks the data channel to its issuer for the whole burst,
// and the client index is appended as the command tag MSB so responses can be
// steered back. Define MEM_ARB_RR_EN for round-robin; otherwise client 0 has
// fixed priority.
module mem_port_arbiter #(
  parameter int unsigned ADDR_BITS  = 26,
  parameter int unsigned TAG_BITS   = 5,
  parameter int unsigned DATA_BITS  = 128,
  parameter int unsigned DATA_BEATS = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave  io_in0,
  mem_port_arbiter_if.slave  io_in1,
  mem_port_arbiter_if.master io_out
);

  localparam int unsigned BeatW = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(DATA_BEATS - 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StWdata = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic [BeatW-1:0] beat_q, beat_d;
`ifdef MEM_ARB_RR_EN
  logic             prio_q, prio_d;
`endif

  logic gnt;
  logic idle;
  logic wdata;
  logic cmd_fire;
  logic data_fire;
  logic resp_sel;

  assign idle  = (state_q == StIdle) && !reset;
  assign wdata = (state_q == StWdata) && !reset;

  // Grant selection; stable while the granted client waits since prio only moves on a fire.
  always_comb begin
`ifdef MEM_ARB_RR_EN
    gnt = prio_q ? io_in1.req_cmd_valid : !io_in0.req_cmd_valid;
`else
    gnt = !io_in0.req_cmd_valid;
`endif
  end

  // Command channel mux; only open in IDLE.
  always_comb begin
    io_out.req_cmd_valid     = idle && (gnt ? io_in1.req_cmd_valid : io_in0.req_cmd_valid);
    io_out.req_cmd_bits_rw   = gnt ? io_in1.req_cmd_bits_rw : io_in0.req_cmd_bits_rw;
    io_out.req_cmd_bits_addr = gnt ? io_in1.req_cmd_bits_addr : io_in0.req_cmd_bits_addr;
    io_out.req_cmd_bits_tag  = {gnt, (gnt ? io_in1.req_cmd_bits_tag : io_in0.req_cmd_bits_tag)};
    io_in0.req_cmd_ready     = idle && !gnt && io_out.req_cmd_ready;
    io_in1.req_cmd_ready     = idle && gnt && io_out.req_cmd_ready;
  end

  // Write-data mux; connected to the burst owner only while in WDATA.
  always_comb begin
    io_out.req_data_valid     = wdata &&
                                (owner_q ? io_in1.req_data_valid : io_in0.req_data_valid);
    io_out.req_data_bits_data = owner_q ? io_in1.req_data_bits_data
                                        : io_in0.req_data_bits_data;
    io_in0.req_data_ready     = wdata && !owner_q && io_out.req_data_ready;
    io_in1.req_data_ready     = wdata && owner_q && io_out.req_data_ready;
  end

  // Response steering by the tag MSB, independent of arbitration state.
  always_comb begin
    resp_sel              = io_out.resp_bits_tag[TAG_BITS];
    io_in0.resp_valid     = !reset && !resp_sel && io_out.resp_valid;
    io_in1.resp_valid     = !reset && resp_sel && io_out.resp_valid;
    io_in0.resp_bits_tag  = io_out.resp_bits_tag[TAG_BITS-1:0];
    io_in1.resp_bits_tag  = io_out.resp_bits_tag[TAG_BITS-1:0];
    io_in0.resp_bits_data = io_out.resp_bits_data;
    io_in1.resp_bits_data = io_out.resp_bits_data;
    io_out.resp_ready     = !reset && (resp_sel ? io_in1.resp_ready : io_in0.resp_ready);
  end

  assign cmd_fire  = io_out.req_cmd_valid && io_out.req_cmd_ready;
  assign data_fire = io_out.req_data_valid && io_out.req_data_ready;

  // Next-state: enter WDATA on a write command, leave after the last beat fires.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    beat_d  = beat_q;
`ifdef MEM_ARB_RR_EN
    prio_d  = prio_q;
`endif
    case (state_q)
      StIdle: begin
        if (cmd_fire) begin
`ifdef MEM_ARB_RR_EN
          prio_d = !gnt;
`endif
          if (io_out.req_cmd_bits_rw) begin
            owner_d = gnt;
            beat_d  = '0;
            state_d = StWdata;
          end
        end
      end
      default: begin
        if (data_fire) begin
          if (beat_q == LastBeat) begin
            beat_d  = '0;
            state_d = StIdle;
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
      end
    endcase
  end

  // State registers with synchronous reset; reset aborts any burst in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      beat_q  <= '0;
`ifdef MEM_ARB_RR_EN
      prio_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
`ifdef MEM_ARB_RR_EN
      prio_q  <= prio_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs change 1 time unit after the
// rising edge; combinational outputs are checked mid-cycle.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  mem_port_arbiter_if #(.ADDR_BITS(26), .TAG_W(5), .DATA_BITS(128)) if_in0 ();
  mem_port_arbiter_if #(.ADDR_BITS(26), .TAG_W(5), .DATA_BITS(128)) if_in1 ();
  mem_port_arbiter_if #(.ADDR_BITS(26), .TAG_W(6), .DATA_BITS(128)) if_out ();

  mem_port_arbiter #(
    .ADDR_BITS (26),
    .TAG_BITS  (5),
    .DATA_BITS (128),
    .DATA_BEATS(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_in0(if_in0),
    .io_in1(if_in1),
    .io_out(if_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_in0.req_cmd_valid = 0; if_in0.req_cmd_bits_rw = 0;
    if_in0.req_cmd_bits_addr = '0; if_in0.req_cmd_bits_tag = '0;
    if_in0.req_data_valid = 0; if_in0.req_data_bits_data = '0; if_in0.resp_ready = 0;
    if_in1.req_cmd_valid = 0; if_in1.req_cmd_bits_rw = 0;
    if_in1.req_cmd_bits_addr = '0; if_in1.req_cmd_bits_tag = '0;
    if_in1.req_data_valid = 0; if_in1.req_data_bits_data = '0; if_in1.resp_ready = 0;
    if_out.req_cmd_ready = 0; if_out.req_data_ready = 0; if_out.resp_valid = 0;
    if_out.resp_bits_tag = '0; if_out.resp_bits_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    if_in0.req_cmd_valid = 1; if_in1.req_cmd_valid = 1;
    if_in0.req_data_valid = 1; if_in1.req_data_valid = 1;
    if_out.req_cmd_ready = 1; if_out.req_data_ready = 1;
    if_out.resp_valid = 1; if_out.resp_bits_tag = 6'h25;
    if_in0.resp_ready = 1; if_in1.resp_ready = 1;
    step();
    #2;
    checks++;
    if (if_out.req_cmd_valid !== 1'b0) begin
      errors++; $display("FAIL reset_cmd_valid: got %b want 0", if_out.req_cmd_valid);
    end
    checks++;
    if ({if_in0.req_cmd_ready, if_in1.req_cmd_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_cmd_ready: got %b want 00",
                         {if_in0.req_cmd_ready, if_in1.req_cmd_ready});
    end
    checks++;
    if ({if_out.req_data_valid, if_in0.req_data_ready, if_in1.req_data_ready} !== 3'b000) begin
      errors++; $display("FAIL reset_data: got %b want 000",
                         {if_out.req_data_valid, if_in0.req_data_ready, if_in1.req_data_ready});
    end
    checks++;
    if ({if_in1.resp_valid, if_out.resp_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_resp: got %b want 00", {if_in1.resp_valid, if_out.resp_ready});
    end
    reset = 0;
    clear_inputs();
    step();
  endtask

  // Both clients issue reads; covers grant order, hold-until-fire and no data in IDLE.
  task automatic test_arbitration();
    logic       exp_gnt;
    logic [5:0] exp_tag;
    do_reset();
    if_in0.req_cmd_valid = 1; if_in0.req_cmd_bits_tag = 5'h0A;
    if_in0.req_cmd_bits_addr = 26'h100;
    if_in1.req_cmd_valid = 1; if_in1.req_cmd_bits_tag = 5'h13;
    if_in1.req_cmd_bits_addr = 26'h200;
    if_in0.req_data_valid = 1; if_out.req_data_ready = 1;
    // Not ready for two cycles: grant must stay on client 0.
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++;
      if ({if_out.req_cmd_valid, if_out.req_cmd_bits_tag} !== {1'b1, 6'h0A}) begin
        errors++; $display("FAIL hold_grant[%0d]: got v=%b tag=%h want v=1 tag=0a", i,
                           if_out.req_cmd_valid, if_out.req_cmd_bits_tag);
      end
      checks++;
      if ({if_in0.req_cmd_ready, if_in1.req_cmd_ready} !== 2'b00) begin
        errors++; $display("FAIL hold_ready[%0d]: got %b want 00", i,
                           {if_in0.req_cmd_ready, if_in1.req_cmd_ready});
      end
      step();
    end
    if_out.req_cmd_ready = 1;
    for (int i = 0; i < 5; i++) begin
`ifdef MEM_ARB_RR_EN
      exp_gnt = (i % 2 == 1);
`else
      exp_gnt = 1'b0;
`endif
      exp_tag = exp_gnt ? 6'h33 : 6'h0A;
      #2;
      checks++;
      if (if_out.req_cmd_bits_tag !== exp_tag) begin
        errors++; $display("FAIL rr_tag[%0d]: got %h want %h", i, if_out.req_cmd_bits_tag, exp_tag);
      end
      checks++;
      if ({if_in1.req_cmd_ready, if_in0.req_cmd_ready} !== {exp_gnt, !exp_gnt}) begin
        errors++; $display("FAIL rr_ready[%0d]: got %b want %b", i,
                           {if_in1.req_cmd_ready, if_in0.req_cmd_ready}, {exp_gnt, !exp_gnt});
      end
      checks++;
      if (if_out.req_cmd_bits_addr !== (exp_gnt ? 26'h200 : 26'h100)) begin
        errors++; $display("FAIL rr_addr[%0d]: got %h", i, if_out.req_cmd_bits_addr);
      end
      checks++;
      if ({if_out.req_data_valid, if_in0.req_data_ready} !== 2'b00) begin
        errors++; $display("FAIL idle_data[%0d]: got %b want 00", i,
                           {if_out.req_data_valid, if_in0.req_data_ready});
      end
      step();
    end
    // Client 0 drops valid: client 1 must win that cycle.
    if_in0.req_cmd_valid = 0;
    #2;
    checks++;
    if ({if_out.req_cmd_valid, if_out.req_cmd_bits_tag, if_in1.req_cmd_ready} !==
        {1'b1, 6'h33, 1'b1}) begin
      errors++; $display("FAIL drop0_grant1: got v=%b tag=%h rdy1=%b want 1 33 1",
                         if_out.req_cmd_valid, if_out.req_cmd_bits_tag, if_in1.req_cmd_ready);
    end
    step();
    clear_inputs();
  endtask

  // Client 1 four-beat write with a 3-cycle stall at beat 2.
  task automatic test_write_burst();
    do_reset();
    if_in1.req_cmd_valid = 1; if_in1.req_cmd_bits_rw = 1;
    if_in1.req_cmd_bits_addr = 26'h155; if_in1.req_cmd_bits_tag = 5'h03;
    if_out.req_cmd_ready = 1;
    #2;
    checks++;
    if ({if_out.req_cmd_valid, if_out.req_cmd_bits_rw, if_out.req_cmd_bits_tag,
         if_out.req_cmd_bits_addr} !== {1'b1, 1'b1, 6'h23, 26'h155}) begin
      errors++; $display("FAIL wr_cmd: got v=%b rw=%b tag=%h addr=%h want 1 1 23 155",
                         if_out.req_cmd_valid, if_out.req_cmd_bits_rw,
                         if_out.req_cmd_bits_tag, if_out.req_cmd_bits_addr);
    end
    step();
    if_in1.req_cmd_valid = 0;
    if_in0.req_cmd_valid = 1; if_in0.req_cmd_bits_tag = 5'h0A;
    if_in0.req_data_valid = 1; if_in0.req_data_bits_data = 128'hDEAD;
    if_in1.req_data_valid = 1;
    if_out.resp_valid = 1; if_out.resp_bits_tag = 6'h21; if_in1.resp_ready = 1;
    for (int b = 0; b < 4; b++) begin
      if_in1.req_data_bits_data = 128'hB000 + 128'(b);
      if_out.req_data_ready = (b != 2);
      for (int s = 0; s < ((b == 2) ? 4 : 1); s++) begin
        if (b == 2 && s == 3) if_out.req_data_ready = 1;
        #2;
        checks++;
        if (if_out.req_data_bits_data !== 128'hB000 + 128'(b)) begin
          errors++; $display("FAIL wr_data[%0d.%0d]: got %h want %h", b, s,
                             if_out.req_data_bits_data, 128'hB000 + 128'(b));
        end
        checks++;
        if ({if_out.req_data_valid, if_in1.req_data_ready, if_in0.req_data_ready} !==
            {1'b1, if_out.req_data_ready, 1'b0}) begin
          errors++; $display("FAIL wr_chan[%0d.%0d]: got %b want %b", b, s,
                             {if_out.req_data_valid, if_in1.req_data_ready,
                              if_in0.req_data_ready}, {1'b1, if_out.req_data_ready, 1'b0});
        end
        checks++;
        if ({if_out.req_cmd_valid, if_in0.req_cmd_ready} !== 2'b00) begin
          errors++; $display("FAIL wr_cmd_blocked[%0d.%0d]: got %b want 00", b, s,
                             {if_out.req_cmd_valid, if_in0.req_cmd_ready});
        end
        if (b == 0) begin
          checks++;
          if ({if_in1.resp_valid, if_in0.resp_valid, if_out.resp_ready} !== 3'b101) begin
            errors++; $display("FAIL wr_resp: got %b want 101",
                               {if_in1.resp_valid, if_in0.resp_valid, if_out.resp_ready});
          end
        end
        step();
      end
    end
    #2;
    checks++;
    if ({if_out.req_data_valid, if_in1.req_data_ready, if_in0.req_cmd_ready,
         if_out.req_cmd_bits_tag} !== {1'b0, 1'b0, 1'b1, 6'h0A}) begin
      errors++; $display("FAIL wr_exit: got dv=%b rdy1=%b crdy0=%b tag=%h want 0 0 1 0a",
                         if_out.req_data_valid, if_in1.req_data_ready,
                         if_in0.req_cmd_ready, if_out.req_cmd_bits_tag);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_response();
    clear_inputs();
    if_out.resp_valid = 1; if_out.resp_bits_tag = 6'h25; if_out.resp_bits_data = 128'hA5A5;
    if_in1.resp_ready = 1; if_in0.resp_ready = 0;
    #2;
    checks++;
    if ({if_in1.resp_valid, if_in0.resp_valid, if_in1.resp_bits_tag, if_out.resp_ready} !==
        {1'b1, 1'b0, 5'h05, 1'b1}) begin
      errors++; $display("FAIL resp_c1: got v1=%b v0=%b tag=%h rdy=%b want 1 0 05 1",
                         if_in1.resp_valid, if_in0.resp_valid, if_in1.resp_bits_tag,
                         if_out.resp_ready);
    end
    checks++;
    if (if_in1.resp_bits_data !== 128'hA5A5) begin
      errors++; $display("FAIL resp_data: got %h want a5a5", if_in1.resp_bits_data);
    end
    if_in1.resp_ready = 0;
    #2;
    checks++;
    if (if_out.resp_ready !== 1'b0) begin
      errors++; $display("FAIL resp_backpressure: got %b want 0", if_out.resp_ready);
    end
    step();
    if_out.resp_bits_tag = 6'h05; if_in0.resp_ready = 1; if_in1.resp_ready = 0;
    #2;
    checks++;
    if ({if_in0.resp_valid, if_in1.resp_valid, if_in0.resp_bits_tag, if_out.resp_ready} !==
        {1'b1, 1'b0, 5'h05, 1'b1}) begin
      errors++; $display("FAIL resp_c0: got v0=%b v1=%b tag=%h rdy=%b want 1 0 05 1",
                         if_in0.resp_valid, if_in1.resp_valid, if_in0.resp_bits_tag,
                         if_out.resp_ready);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    if_in1.req_cmd_valid = 1; if_in1.req_cmd_bits_rw = 1; if_in1.req_cmd_bits_tag = 5'h03;
    if_out.req_cmd_ready = 1;
    step();
    if_in1.req_cmd_valid = 0;
    if_in1.req_data_valid = 1; if_out.req_data_ready = 1;
    step();
    step();
    reset = 1;
    #2;
    checks++;
    if ({if_out.req_data_valid, if_in1.req_data_ready} !== 2'b00) begin
      errors++; $display("FAIL rst_mid_gate: got %b want 00",
                         {if_out.req_data_valid, if_in1.req_data_ready});
    end
    step();
    reset = 0;
    if_in0.req_cmd_valid = 1; if_in0.req_cmd_bits_tag = 5'h0A;
    if_in1.req_cmd_valid = 1; if_in1.req_cmd_bits_tag = 5'h13;
    #2;
    checks++;
    if ({if_out.req_data_valid, if_in1.req_data_ready} !== 2'b00) begin
      errors++; $display("FAIL rst_mid_idle: got %b want 00",
                         {if_out.req_data_valid, if_in1.req_data_ready});
    end
    checks++;
    if ({if_out.req_cmd_valid, if_out.req_cmd_bits_tag, if_in0.req_cmd_ready} !==
        {1'b1, 6'h0A, 1'b1}) begin
      errors++; $display("FAIL rst_mid_grant: got v=%b tag=%h rdy0=%b want 1 0a 1",
                         if_out.req_cmd_valid, if_out.req_cmd_bits_tag, if_in0.req_cmd_ready);
    end
    step();
    clear_inputs();
  endtask

  initial begin
    clk = 0;
    reset = 1;
    errors = 0;
    checks = 0;
    clear_inputs();
    test_reset();
    test_arbitration();
    test_write_burst();
    test_response();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-client arbiter that shares the single off-chip memory port (req_cmd / req_data / resp) between the processor's uncore port (client 0) and the backup-memory path (client 1). It sits between those requesters and the harness memory model, or the pad-side serializer in silicon. It grants command slots in round-robin order, holds the data channel for the whole write burst, and extends each tag with a client-ID bit. That bit is used to steer responses back to the client that issued the request.

## Interface
- ADDR_BITS, 26, client and memory address width
- TAG_BITS, 5, client tag width; memory-side tag width is TAG_BITS+1
- DATA_BITS, 128, data beat width
- DATA_BEATS, 4, data beats per write request; must be ≥1

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- io_in{0,1}_req_cmd_valid / _ready  in / out  1  client command handshake
- io_in{0,1}_req_cmd_bits_rw  in  1  1 = write, 0 = read
- io_in{0,1}_req_cmd_bits_addr  in  ADDR_BITS  block address
- io_in{0,1}_req_cmd_bits_tag  in  TAG_BITS  client tag
- io_in{0,1}_req_data_valid / _ready  in / out  1  client write-data handshake
- io_in{0,1}_req_data_bits_data  in  DATA_BITS  write beat
- io_in{0,1}_resp_valid / _ready  out / in  1  client response handshake
- io_in{0,1}_resp_bits_tag  out  TAG_BITS  returned client tag
- io_in{0,1}_resp_bits_data  out  DATA_BITS  read beat
- io_out_req_cmd_valid / _ready  out / in  1  memory command handshake
- io_out_req_cmd_bits_rw  out  1
- io_out_req_cmd_bits_addr  out  ADDR_BITS
- io_out_req_cmd_bits_tag  out  TAG_BITS+1  {client_id, client_tag}
- io_out_req_data_valid / _ready  out / in  1
- io_out_req_data_bits_data  out  DATA_BITS
- io_out_resp_valid / _ready  in / out  1
- io_out_resp_bits_tag  in  TAG_BITS+1
- io_out_resp_bits_data  in  DATA_BITS

## Operation
- State: `state` ∈ {IDLE, WDATA}, `owner` (1 bit), `beat` (log2(DATA_BEATS) bits, min 1), `prio` (1 bit, the client favoured next).
- IDLE:
  - The grant is combinational. Pick `prio` if it is valid, otherwise the other client.
  - Drive the granted client's cmd fields onto io_out. Append tag MSB = client index.
  - io_out_req_cmd_valid = granted client's valid.
  - Only the granted client's cmd_ready = io_out_req_cmd_ready. The loser's cmd_ready = 0.
- Command fire (valid & ready):
  - `prio` ← ~granted.
  - If rw = 1: `owner` ← granted, `beat` ← 0, state → WDATA.
  - If rw = 0: stay in IDLE.
- WDATA:
  - Both cmd_ready = 0 and io_out_req_cmd_valid = 0.
  - The data channel connects `owner` to io_out. The non-owner's data_ready = 0.
  - Each data fire increments `beat`. The fire with beat = DATA_BEATS-1 returns to IDLE.
- Data channel in IDLE: io_out_req_data_valid = 0 and both client data_ready = 0. Write data always follows its command.
- Response path is combinational and independent of `state`:
  - sel = io_out_resp_bits_tag[TAG_BITS].
  - io_in{sel}_resp_valid = io_out_resp_valid. The other client's resp_valid = 0.
  - Both clients receive tag[TAG_BITS-1:0] and data.
  - io_out_resp_ready = io_in{sel}_resp_ready.
- Responses may arrive in any order and during WDATA. They never affect arbitration.

## Timing
- Command, data and response paths each have zero-cycle latency (pure muxing). There is no buffering.
- Back-to-back reads: one grant per cycle, alternating when both clients are valid.
- Write of N beats occupies the cmd channel for 1 + (cycles to complete N data fires). The earliest next grant is the cycle after the last beat fires.
- A client's valid may drop while it is not granted. Once granted with valid and not yet ready, its fields must hold stable; the arbiter keeps that grant in IDLE until the fire.
- Reset:
  - state = IDLE, prio = 0, beat = 0, owner = 0.
  - While reset is high, all valid and ready outputs are forced to 0.
- Reset mid-burst aborts the burst. The remaining beats are never requested, and the cycle after reset deasserts is IDLE.

## Configuration
- MEM_ARB_RR_EN defined: round-robin via `prio` as above.
- MEM_ARB_RR_EN undefined: fixed priority, client 0 always wins, and `prio` is not implemented. Client 1 is granted only when client 0's cmd_valid = 0.

## Test plan
- Both clients hold read cmd valid, io_out_req_cmd_ready = 1 for 4 cycles (RR_EN) -> out tags 0x20|t0? No: tags are {0,t0},{1,t1},{0,t0},{1,t1}; grant alternates 0,1,0,1.
- Client 1 write (addr 0x155, tag 3) while client 0 issues reads -> out cmd tag 0x23, rw = 1. The next 4 data beats come only from client 1. Client 0 cmd_ready = 0 until the cycle after beat 3 fires.
- During WDATA, deassert io_out_req_data_ready for 3 cycles at beat 2 -> beat count holds. Data 2 is held on io_out. State exits only after the 4th fire.
- Memory returns resp tag 0x25 then 0x05 -> client 1 sees tag 5, then client 0 sees tag 5. Holding io_in1_resp_ready = 0 drives io_out_resp_ready = 0.
- Assert reset after beat 1 of a write -> the next cycle after release is IDLE, all valids are 0, and client 0 wins the first grant (prio = 0).
- RR_EN undefined, both clients continuously valid with reads -> client 0 wins every cycle; client 1 wins the first cycle client 0 drops valid.
